apb_requester: RTL and testbench
================================

Name: apb_requester

Overview:
- APB4 requester (bridge) FSM. Converts single transfer requests from a valid/ready command port into APB SETUP/ACCESS phases on the bridge side of the APB interface.
- Returns read data and error status on a valid/ready response port.
- Sits directly upstream of the APB peripheral and drives the bridge modport signals; one outstanding transfer at a time.

Parameters:
- ADDR_WIDTH, 32, width of cmd_addr and paddr
- DATA_WIDTH, 32, width of write/read data buses
- STRB_WIDTH, DATA_WIDTH/8, byte-strobe width
- TIMEOUT_CYCLES, 16, maximum ACCESS-phase wait cycles; used only with APB_REQ_TIMEOUT_EN

Ports:
- pclk  in  1  APB clock, all logic on rising edge
- preset  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  transfer address
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_strb  in  STRB_WIDTH  write byte strobes
- cmd_prot  in  3  protection attributes
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes
- rsp_err  out  1  transfer error
- paddr  out  ADDR_WIDTH  APB address
- psel  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- pwdata  out  DATA_WIDTH  APB write data
- pstrb  out  STRB_WIDTH  APB strobes
- pprot  out  3  APB protection
- prdata  in  DATA_WIDTH  APB read data
- pready  in  1  APB ready
- pslverr  in  1  APB slave error

Behaviour:
- Clocking and reset:
  - One clock; reset is asynchronous and active-high.
  - While preset = 1, all outputs are 0 and the state is IDLE.
  - After preset deasserts, cmd_ready = 1.
- States: IDLE, SETUP, ACCESS, RESP. All outputs are registered except cmd_ready, which equals (state == IDLE).
- IDLE:
  - On cmd_valid && cmd_ready, latch the command and go to SETUP.
  - paddr, pwrite, pwdata and pprot load from the command.
  - pstrb loads cmd_strb for writes and 0 for reads (APB4 rule).
- SETUP: psel = 1, penable = 0 for exactly one cycle, then go to ACCESS.
- ACCESS:
  - psel = 1, penable = 1.
  - paddr, pwrite, pwdata, pstrb and pprot stay stable until completion.
  - Each cycle, sample pready. On pready = 1:
    - Capture rsp_rdata = prdata for reads, 0 for writes.
    - Capture rsp_err = pslverr.
    - Next cycle: psel = 0, penable = 0, rsp_valid = 1, state RESP.
- RESP:
  - rsp_valid, rsp_rdata and rsp_err hold until rsp_ready = 1, then go to IDLE.
  - psel stays 0 throughout.
- Back-to-back transfers: a new command is accepted in the first IDLE cycle after the response handshake. No SETUP is ever driven while rsp_valid = 1.
- Latency: command accept at cycle N gives SETUP at N+1 and ACCESS at N+2. With zero wait states, rsp_valid = 1 at N+3. Each pready-low cycle adds 1.
- pready, prdata and pslverr are ignored outside ACCESS.
- penable is never 1 while psel = 0.
- APB address/data outputs keep their last values after completion; psel and penable return to 0.
- Reset mid-operation: psel, penable and rsp_valid clear immediately. The in-flight transfer is discarded and no response is produced.

Optional Feature:
- Macro: APB_REQ_TIMEOUT_EN.
- When defined:
  - A wait counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to ACCESS.
  - It increments each ACCESS cycle with pready = 0.
  - When it reaches TIMEOUT_CYCLES and pready is still 0, the transfer terminates: next cycle psel = 0, penable = 0, rsp_valid = 1, rsp_err = 1, rsp_rdata = 0, state RESP.
  - pready = 1 on the same cycle the counter reaches TIMEOUT_CYCLES completes normally, and pready wins.
- When not defined: ACCESS waits indefinitely and no counter is synthesised.

Test Plan:
- Reset: preset = 1 mid-ACCESS -> psel = 0, penable = 0, rsp_valid = 0 immediately. After release, cmd_ready = 1 and state is IDLE.
- Zero-wait write: addr 0x0000_0010, wdata 0xDEAD_BEEF, strb 0xF, pready tied 1 -> SETUP at N+1, ACCESS at N+2, rsp_valid at N+3 with rsp_err = 0, rsp_rdata = 0.
- Read with 3 wait states: addr 0x24, prdata 0x1234_5678 shown with pready = 1 on the 4th ACCESS cycle -> rsp_rdata = 0x1234_5678, rsp_valid at N+6. During the read, pstrb = 0 and paddr/pwrite are stable throughout ACCESS.
- Slave error: write with pslverr = 1 alongside pready = 1 -> rsp_err = 1. A new command is not accepted until rsp_ready is asserted.
- Back-pressure and back-to-back: hold rsp_ready = 0 for 5 cycles with cmd_valid = 1 -> cmd_ready stays 0 and psel stays 0. Assert rsp_ready -> the next command is accepted in the following cycle.
- APB_REQ_TIMEOUT_EN with TIMEOUT_CYCLES = 4 and pready held 0 -> after 4 ACCESS cycles, rsp_err = 1, rsp_rdata = 0, psel = 0. Repeat with pready = 1 on the 4th cycle -> normal completion, rsp_err = pslverr.

Source files
------------

// File: rtl/apb_requester.sv
// APB4 requester: turns one valid/ready command into an APB SETUP/ACCESS
// transfer and returns read data / error status on a valid/ready response.
// Optional build macro APB_REQ_TIMEOUT_EN bounds the ACCESS wait to
// TIMEOUT_CYCLES cycles and ends a stalled transfer with rsp_err = 1.
//
// state  | meaning
// IDLE   | ready for a command, APB bus idle
// SETUP  | psel = 1, penable = 0 for one cycle
// ACCESS | psel = 1, penable = 1, waiting for pready
// RESP   | response held on rsp_* until rsp_ready
module apb_requester #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_strb,
  input  logic [2:0]            cmd_prot,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [DATA_WIDTH-1:0] pwdata,
  output logic [STRB_WIDTH-1:0] pstrb,
  output logic [2:0]            pprot,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  // A zero timeout would make the wait-count compare meaningless.
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("apb_requester: TIMEOUT_CYCLES must be at least 1");
  end

  logic [1:0] state;

`ifdef APB_REQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] wait_cnt;
`endif

  // Commands are only taken in IDLE; held low through reset so every output reads 0.
  assign cmd_ready = (state == IDLE) && !preset;

  // Transfer sequencing, APB outputs and response capture.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state     <= IDLE;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      pstrb     <= '0;
      pprot     <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
`ifdef APB_REQ_TIMEOUT_EN
      wait_cnt  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            state  <= SETUP;
            psel   <= 1'b1;
            paddr  <= cmd_addr;
            pwrite <= cmd_write;
            pwdata <= cmd_wdata;
            pprot  <= cmd_prot;
            // APB4: strobes must be all-zero on reads.
            pstrb  <= cmd_write ? cmd_strb : '0;
          end
        end
        SETUP: begin
          state   <= ACCESS;
          penable <= 1'b1;
`ifdef APB_REQ_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        ACCESS: begin
          if (pready) begin
            state     <= RESP;
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= pwrite ? '0 : prdata;
            rsp_err   <= pslverr;
          end
`ifdef APB_REQ_TIMEOUT_EN
          // This is the TIMEOUT_CYCLES-th stalled cycle: give up with an error.
          else if (wait_cnt == CNT_LAST) begin
            state     <= RESP;
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            wait_cnt  <= wait_cnt + 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_requester.sv
// Directed bench for apb_requester: reset, zero-wait write, waited read,
// slave error with response back-pressure, back-to-back accept, reset
// mid-ACCESS and, when APB_REQ_TIMEOUT_EN is defined, the ACCESS timeout.
module tb_apb_requester;

  logic        pclk = 1'b0;
  logic        preset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_strb;
  logic [2:0]  cmd_prot;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] paddr, pwdata, prdata;
  logic        psel, penable, pwrite, pready, pslverr;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;

  int checks   = 0;
  int failures = 0;

  apb_requester #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .STRB_WIDTH(4), .TIMEOUT_CYCLES(4)
  ) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle 1 time unit past the rising edge.
  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic set_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [2:0] p);
    cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_strb = s; cmd_prot = p;
  endtask

  initial begin
    preset = 1'b1;
    cmd_valid = 1'b0; rsp_ready = 1'b0;
    set_cmd(1'b0, 32'h0, 32'h0, 4'h0, 3'h0);
    prdata = 32'h0; pready = 1'b0; pslverr = 1'b0;

    // Reset state
    step(); step();
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_psel", psel, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    preset = 1'b0;
    #1;
    chk("post_rst_cmd_ready", cmd_ready, 1);

    // Zero-wait write
    step();
    pready = 1'b1;
    prdata = 32'hFFFF_FFFF;
    set_cmd(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 3'h2);
    cmd_valid = 1'b1;
    step();                                   // N+1: SETUP
    cmd_valid = 1'b0;
    chk("wr_setup_psel", psel, 1);
    chk("wr_setup_penable", penable, 0);
    chk("wr_setup_paddr", paddr, 32'h10);
    chk("wr_setup_pwdata", pwdata, 32'hDEAD_BEEF);
    chk("wr_setup_pstrb", pstrb, 4'hF);
    chk("wr_setup_pwrite", pwrite, 1);
    chk("wr_setup_pprot", pprot, 3'h2);
    chk("wr_setup_cmd_ready", cmd_ready, 0);
    step();                                   // N+2: ACCESS
    chk("wr_access_psel", psel, 1);
    chk("wr_access_penable", penable, 1);
    step();                                   // N+3: response
    chk("wr_rsp_valid", rsp_valid, 1);
    chk("wr_rsp_err", rsp_err, 0);
    chk("wr_rsp_rdata", rsp_rdata, 0);
    chk("wr_rsp_psel", psel, 0);
    chk("wr_rsp_penable", penable, 0);
    chk("wr_keep_paddr", paddr, 32'h10);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("wr_done_rsp_valid", rsp_valid, 0);
    chk("wr_done_cmd_ready", cmd_ready, 1);

    // Read with 3 wait states
    pready = 1'b0;
    prdata = 32'hAAAA_AAAA;
    set_cmd(1'b0, 32'h0000_0024, 32'h5A5A_5A5A, 4'hF, 3'h0);
    cmd_valid = 1'b1;
    step();                                   // N+1: SETUP
    cmd_valid = 1'b0;
    chk("rd_setup_pstrb", pstrb, 0);
    chk("rd_setup_pwrite", pwrite, 0);
    step();                                   // N+2: ACCESS 1
    for (int i = 1; i <= 3; i++) begin
      chk($sformatf("rd_wait%0d_penable", i), penable, 1);
      chk($sformatf("rd_wait%0d_paddr", i), paddr, 32'h24);
      chk($sformatf("rd_wait%0d_pwrite", i), pwrite, 0);
      chk($sformatf("rd_wait%0d_pstrb", i), pstrb, 0);
      chk($sformatf("rd_wait%0d_rsp_valid", i), rsp_valid, 0);
      step();
    end
    pready = 1'b1;                            // N+5: ACCESS 4
    prdata = 32'h1234_5678;
    step();                                   // N+6
    pready = 1'b0;
    prdata = 32'h0BAD_0BAD;
    chk("rd_rsp_valid", rsp_valid, 1);
    chk("rd_rsp_rdata", rsp_rdata, 32'h1234_5678);
    chk("rd_rsp_err", rsp_err, 0);
    step();
    chk("rd_hold_rsp_valid", rsp_valid, 1);
    chk("rd_hold_rsp_rdata", rsp_rdata, 32'h1234_5678);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // Slave error, then back-pressure with the next command waiting
    pready = 1'b1;
    pslverr = 1'b1;
    set_cmd(1'b1, 32'h0000_0030, 32'h0000_1111, 4'h3, 3'h1);
    cmd_valid = 1'b1;
    step();                                   // SETUP
    set_cmd(1'b1, 32'h0000_0040, 32'h0000_0055, 4'h1, 3'h0);
    step();                                   // ACCESS
    step();                                   // response
    pslverr = 1'b0;
    chk("err_rsp_valid", rsp_valid, 1);
    chk("err_rsp_err", rsp_err, 1);
    for (int i = 1; i <= 5; i++) begin
      chk($sformatf("bp%0d_cmd_ready", i), cmd_ready, 0);
      chk($sformatf("bp%0d_psel", i), psel, 0);
      chk($sformatf("bp%0d_rsp_valid", i), rsp_valid, 1);
      step();
    end
    rsp_ready = 1'b1;
    step();                                   // IDLE
    rsp_ready = 1'b0;
    chk("b2b_idle_cmd_ready", cmd_ready, 1);
    chk("b2b_idle_psel", psel, 0);
    step();                                   // next command in SETUP
    cmd_valid = 1'b0;
    chk("b2b_setup_psel", psel, 1);
    chk("b2b_setup_paddr", paddr, 32'h40);
    chk("b2b_setup_pstrb", pstrb, 4'h1);
    step();
    step();
    chk("b2b_rsp_valid", rsp_valid, 1);
    chk("b2b_rsp_err", rsp_err, 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // Reset in the middle of ACCESS
    pready = 1'b0;
    set_cmd(1'b0, 32'h0000_0050, 32'h0, 4'hF, 3'h0);
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();
    chk("mid_access_penable", penable, 1);
    preset = 1'b1;
    #1;
    chk("mid_rst_psel", psel, 0);
    chk("mid_rst_penable", penable, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_paddr", paddr, 0);
    step();
    preset = 1'b0;
    pready = 1'b1;
    #1;
    chk("mid_rel_cmd_ready", cmd_ready, 1);
    step(); step();
    chk("mid_rel_no_rsp", rsp_valid, 0);
    chk("mid_rel_psel", psel, 0);
    pready = 1'b0;

`ifdef APB_REQ_TIMEOUT_EN
    // Timeout: pready never rises
    prdata = 32'h7777_7777;
    set_cmd(1'b0, 32'h0000_0060, 32'h0, 4'hF, 3'h0);
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();                                   // ACCESS 1
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("to_acc%0d_penable", i), penable, 1);
      chk($sformatf("to_acc%0d_rsp_valid", i), rsp_valid, 0);
      step();
    end
    chk("to_rsp_valid", rsp_valid, 1);
    chk("to_rsp_err", rsp_err, 1);
    chk("to_rsp_rdata", rsp_rdata, 0);
    chk("to_psel", psel, 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // pready on the 4th ACCESS cycle wins over the timeout
    set_cmd(1'b0, 32'h0000_0064, 32'h0, 4'hF, 3'h0);
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();                                   // ACCESS 1
    step(); step(); step();                   // ACCESS 4
    chk("to_edge_penable", penable, 1);
    pready = 1'b1;
    prdata = 32'h0000_CAFE;
    step();
    pready = 1'b0;
    chk("to_edge_rsp_valid", rsp_valid, 1);
    chk("to_edge_rsp_err", rsp_err, 0);
    chk("to_edge_rsp_rdata", rsp_rdata, 32'h0000_CAFE);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
`else
    // Without the timeout, a long stall just keeps waiting
    set_cmd(1'b0, 32'h0000_0060, 32'h0, 4'hF, 3'h0);
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();
    for (int i = 0; i < 20; i++) step();
    chk("nto_wait_penable", penable, 1);
    chk("nto_wait_rsp_valid", rsp_valid, 0);
    pready = 1'b1;
    prdata = 32'h0000_BEEF;
    step();
    pready = 1'b0;
    chk("nto_rsp_valid", rsp_valid, 1);
    chk("nto_rsp_rdata", rsp_rdata, 32'h0000_BEEF);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
